vending_ctrl_multi: RTL
=======================

Name: vending_ctrl_multi

Overview:
Parametrised vending controller: N items, per-item price and stock memories loaded via a config port, and a cash payment path with cancel and timeout. Change is returned as a handshaked, coin-by-coin stream rather than one combinational breakdown. Sits between the coin acceptor/keypad front end and the dispenser/coin-hopper drivers.

Parameters:
NUM_ITEMS, 8, number of selectable items (>=2)
PRICE_W, 8, item price width in cents
BAL_W, 10, balance accumulator width in cents (>= PRICE_W)
STOCK_W, 3, per-item stock counter width
TIMEOUT_CYC, 1500000000, idle cycles in PAY before auto-refund

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
sel_valid  in  1  item selection strobe
sel_index  in  clog2(NUM_ITEMS)  selected item
nickel, dime, quarter, dollar  in  1 each  coin-accepted pulses, 5/10/25/100 cents
cancel  in  1  user cancel
cfg_we  in  1  config write strobe
cfg_index  in  clog2(NUM_ITEMS)  item to configure
cfg_price  in  PRICE_W  price to load
cfg_stock  in  STOCK_W  stock to load
dispensed  out  1  one-cycle dispense pulse
dispensed_index  out  clog2(NUM_ITEMS)  item dispensed (valid with dispensed)
out_of_stock  out  1  one-cycle pulse, selection rejected
coin_reject  out  1  one-cycle pulse, coins received while not accepting
balance  out  BAL_W  current credit in cents
busy  out  1  high in any state but IDLE
chg_valid  out  1  change coin offered
chg_coin  out  4  one-hot {quarter,dime,nickel,penny}
chg_ready  in  1  hopper accepts offered coin

Behaviour:
- Reset (async): state IDLE, balance 0, all prices 0, all stock 0, timer 0, every output 0.
- States: IDLE, PAY, DISPENSE, REFUND.
- IDLE: cfg_we writes price/stock of cfg_index (ignored in other states). On sel_valid: stock==0 -> out_of_stock next cycle, stay IDLE; else latch index, timer=0, -> PAY. Coins in IDLE -> coin_reject, balance unchanged.
- PAY: all same-cycle coin pulses summed; if balance+sum > 2^BAL_W-1, the whole cycle's coins are rejected (coin_reject), else added and timer cleared. Otherwise timer increments. cancel -> REFUND (coins in the same cycle are still credited first). timer==TIMEOUT_CYC -> REFUND. balance >= price (checked after the add) -> balance -= price, -> DISPENSE. Priority: cancel > timeout > purchase.
- DISPENSE: one cycle; dispensed=1, dispensed_index=latched index, stock decremented; -> REFUND if balance>0 else IDLE. Coins -> coin_reject.
- REFUND: greedy change. chg_valid high while balance>0; chg_coin = largest coin <= balance (25,10,5,1). On chg_valid&chg_ready the coin value is subtracted; chg_coin/chg_valid held stable while ready is low. balance==0 -> IDLE, chg_valid low that cycle. cancel/sel/coins ignored (coins -> coin_reject).
- Price 0 with nonzero stock: dispenses on the PAY entry cycle.
- Reset mid-REFUND: undelivered change discarded; chg_valid drops asynchronously.
- Outputs registered; selection-to-PAY latency 1 cycle; final coin-to-DISPENSE latency 1 cycle.

Optional Feature:
VENDING_CARD_PAY_EN: adds inputs card_valid (1) and card_funds (BAL_W), plus output card_decline (1). In PAY, card_valid with card_funds >= price -> DISPENSE without debiting balance, and any coin balance is then refunded. card_funds < price -> card_decline pulse, stay PAY, timer cleared. Priority: cancel > card > coins. Without the macro these ports are absent and there is no card logic.

Decomposition:
Package vending_pkg: state enum, coin value constants (PENNY=1, NICKEL=5, DIME=10, QUARTER=25, DOLLAR=100), chg_coin one-hot encodings.
Sub-module change_streamer: owns the greedy coin selection and the valid/ready handshake, and returns a debit amount to the main FSM.

Test Plan:
- Config item 2 price 75 stock 1; select 2, insert quarter×3 -> dispensed with index 2, balance 0, returns to IDLE; reselect 2 -> out_of_stock.
- Item 0 price 65; dollar -> dispense, then change stream quarter, dime, with balance going 35->10->0.
- Item 1 price 50; dime+nickel same cycle then cancel -> one dime, then one nickel; chg_ready held low 3 cycles keeps chg_coin stable.
- TIMEOUT_CYC=20; select item, insert quarter, no further input -> REFUND exactly 20 cycles after the coin, one quarter returned.
- BAL_W=7; balance 100, dollar inserted -> coin_reject, balance stays 100.
- rst asserted mid-REFUND -> chg_valid 0 immediately; all stock and prices 0 afterwards.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared types and constants for the multi-item vending controller:
// FSM states, coin values and the one-hot change-coin encoding.
package vending_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAY,
        ST_DISPENSE,
        ST_REFUND
    } state_e;

    localparam int PENNY   = 1;
    localparam int NICKEL  = 5;
    localparam int DIME    = 10;
    localparam int QUARTER = 25;
    localparam int DOLLAR  = 100;

    // chg_coin bit order is {quarter, dime, nickel, penny}
    localparam logic [3:0] CHG_PENNY   = 4'b0001;
    localparam logic [3:0] CHG_NICKEL  = 4'b0010;
    localparam logic [3:0] CHG_DIME    = 4'b0100;
    localparam logic [3:0] CHG_QUARTER = 4'b1000;

    // Worst case is all four pulses together: 140 cents, fits in 8 bits.
    function automatic logic [7:0] coin_sum(input logic n, input logic d,
                                            input logic q, input logic dl);
        return (n  ? 8'(NICKEL)  : 8'd0) + (d  ? 8'(DIME)   : 8'd0) +
               (q  ? 8'(QUARTER) : 8'd0) + (dl ? 8'(DOLLAR) : 8'd0);
    endfunction

endpackage

// File: rtl/change_streamer.sv
// Greedy change selection with a valid/ready coin handshake; reports the
// value of the coin taken this cycle so the controller can debit the balance.
module change_streamer
    import vending_pkg::*;
#(
    parameter int BAL_W = 10
) (
    input  logic             active,
    input  logic [BAL_W-1:0] balance,
    input  logic             chg_ready,
    output logic             chg_valid,
    output logic [3:0]       chg_coin,
    output logic [BAL_W-1:0] debit
);

    logic [BAL_W-1:0] coin_val;
    logic [3:0]       coin_sel;

    always_comb begin
        coin_val = '0;
        coin_sel = '0;
        if (balance >= BAL_W'(QUARTER)) begin
            coin_val = BAL_W'(QUARTER);
            coin_sel = CHG_QUARTER;
        end else if (balance >= BAL_W'(DIME)) begin
            coin_val = BAL_W'(DIME);
            coin_sel = CHG_DIME;
        end else if (balance >= BAL_W'(NICKEL)) begin
            coin_val = BAL_W'(NICKEL);
            coin_sel = CHG_NICKEL;
        end else if (balance != '0) begin
            coin_val = BAL_W'(PENNY);
            coin_sel = CHG_PENNY;
        end
    end

    // Driven only from registered state, so the offer is stable while the
    // hopper stalls and collapses immediately on reset.
    assign chg_valid = active && (balance != '0);
    assign chg_coin  = chg_valid ? coin_sel : 4'b0000;
    assign debit     = (chg_valid && chg_ready) ? coin_val : '0;

endmodule

// File: rtl/vending_ctrl_multi.sv
// Multi-item vending controller: config-loaded price/stock tables, cash
// payment with cancel/timeout, streamed change. Card payment under VENDING_CARD_PAY_EN.
module vending_ctrl_multi
    import vending_pkg::*;
#(
    parameter int NUM_ITEMS   = 8,
    parameter int PRICE_W     = 8,
    parameter int BAL_W       = 10,
    parameter int STOCK_W     = 3,
    parameter int TIMEOUT_CYC = 1500000000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sel_valid,
    input  logic [$clog2(NUM_ITEMS)-1:0] sel_index,
    input  logic                         nickel,
    input  logic                         dime,
    input  logic                         quarter,
    input  logic                         dollar,
    input  logic                         cancel,
    input  logic                         cfg_we,
    input  logic [$clog2(NUM_ITEMS)-1:0] cfg_index,
    input  logic [PRICE_W-1:0]           cfg_price,
    input  logic [STOCK_W-1:0]           cfg_stock,
`ifdef VENDING_CARD_PAY_EN
    input  logic                         card_valid,
    input  logic [BAL_W-1:0]             card_funds,
    output logic                         card_decline,
`endif
    output logic                         dispensed,
    output logic [$clog2(NUM_ITEMS)-1:0] dispensed_index,
    output logic                         out_of_stock,
    output logic                         coin_reject,
    output logic [BAL_W-1:0]             balance,
    output logic                         busy,
    output logic                         chg_valid,
    output logic [3:0]                   chg_coin,
    input  logic                         chg_ready
);

    localparam int IDX_W = $clog2(NUM_ITEMS);
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam int SUM_W = BAL_W + 8;

    state_e             state_q, state_d;
    logic [BAL_W-1:0]   balance_q, balance_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [PRICE_W-1:0] price_q [NUM_ITEMS];
    logic [PRICE_W-1:0] price_d [NUM_ITEMS];
    logic [STOCK_W-1:0] stock_q [NUM_ITEMS];
    logic [STOCK_W-1:0] stock_d [NUM_ITEMS];
    logic               dispensed_q, dispensed_d;
    logic [IDX_W-1:0]   disp_idx_q, disp_idx_d;
    logic               oos_q, oos_d;
    logic               reject_q, reject_d;
`ifdef VENDING_CARD_PAY_EN
    logic               decline_q, decline_d;
`endif

    logic               any_coin;
    logic [SUM_W-1:0]   bal_sum;
    logic               coin_ok;
    logic [BAL_W-1:0]   bal_new;
    logic [BAL_W-1:0]   price_ext;
    logic [TMR_W-1:0]   timer_inc;
    logic [BAL_W-1:0]   debit;

    change_streamer #(.BAL_W(BAL_W)) u_chg (
        .active    (state_q == ST_REFUND),
        .balance   (balance_q),
        .chg_ready (chg_ready),
        .chg_valid (chg_valid),
        .chg_coin  (chg_coin),
        .debit     (debit)
    );

    always_comb begin
        state_d     = state_q;
        balance_d   = balance_q;
        timer_d     = timer_q;
        idx_d       = idx_q;
        price_d     = price_q;
        stock_d     = stock_q;
        dispensed_d = 1'b0;
        disp_idx_d  = disp_idx_q;
        oos_d       = 1'b0;
        reject_d    = 1'b0;
`ifdef VENDING_CARD_PAY_EN
        decline_d   = 1'b0;
`endif
        any_coin  = nickel | dime | quarter | dollar;
        bal_sum   = SUM_W'(balance_q) + SUM_W'(coin_sum(nickel, dime, quarter, dollar));
        // A cycle's coins go in together or not at all.
        coin_ok   = any_coin && (bal_sum[SUM_W-1:BAL_W] == '0);
        bal_new   = coin_ok ? bal_sum[BAL_W-1:0] : balance_q;
        price_ext = BAL_W'(price_q[idx_q]);
        timer_inc = timer_q + TMR_W'(1);

        case (state_q)
            ST_IDLE: begin
                reject_d = any_coin;
                if (cfg_we) begin
                    price_d[cfg_index] = cfg_price;
                    stock_d[cfg_index] = cfg_stock;
                end
                if (sel_valid) begin
                    if (stock_q[sel_index] == '0) begin
                        oos_d = 1'b1;
                    end else begin
                        idx_d   = sel_index;
                        timer_d = '0;
                        state_d = ST_PAY;
                    end
                end
            end
            ST_PAY: begin
                reject_d  = any_coin && !coin_ok;
                balance_d = bal_new;
                timer_d   = coin_ok ? '0 : timer_inc;
                if (cancel) begin
                    state_d = ST_REFUND;
                end
`ifdef VENDING_CARD_PAY_EN
                else if (card_valid) begin
                    if (card_funds >= price_ext) begin
                        state_d     = ST_DISPENSE;
                        dispensed_d = 1'b1;
                        disp_idx_d  = idx_q;
                    end else begin
                        decline_d = 1'b1;
                        timer_d   = '0;
                    end
                end
`endif
                // Expires once TIMEOUT_CYC idle cycles have elapsed.
                else if (!coin_ok && timer_inc == TMR_W'(TIMEOUT_CYC)) begin
                    state_d = ST_REFUND;
                end else if (bal_new >= price_ext) begin
                    balance_d   = bal_new - price_ext;
                    state_d     = ST_DISPENSE;
                    dispensed_d = 1'b1;
                    disp_idx_d  = idx_q;
                end
            end
            ST_DISPENSE: begin
                reject_d       = any_coin;
                stock_d[idx_q] = stock_q[idx_q] - STOCK_W'(1);
                state_d        = (balance_q != '0) ? ST_REFUND : ST_IDLE;
            end
            ST_REFUND: begin
                reject_d  = any_coin;
                balance_d = balance_q - debit;
                if (balance_q == '0) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            balance_q   <= '0;
            timer_q     <= '0;
            idx_q       <= '0;
            price_q     <= '{default: '0};
            stock_q     <= '{default: '0};
            dispensed_q <= 1'b0;
            disp_idx_q  <= '0;
            oos_q       <= 1'b0;
            reject_q    <= 1'b0;
`ifdef VENDING_CARD_PAY_EN
            decline_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            balance_q   <= balance_d;
            timer_q     <= timer_d;
            idx_q       <= idx_d;
            price_q     <= price_d;
            stock_q     <= stock_d;
            dispensed_q <= dispensed_d;
            disp_idx_q  <= disp_idx_d;
            oos_q       <= oos_d;
            reject_q    <= reject_d;
`ifdef VENDING_CARD_PAY_EN
            decline_q   <= decline_d;
`endif
        end
    end

    assign dispensed       = dispensed_q;
    assign dispensed_index = disp_idx_q;
    assign out_of_stock    = oos_q;
    assign coin_reject     = reject_q;
    assign balance         = balance_q;
    assign busy            = (state_q != ST_IDLE);
`ifdef VENDING_CARD_PAY_EN
    assign card_decline    = decline_q;
`endif

endmodule
